tank_shell: RTL
===============

TANK_SHELL -- requirements
Module: tank_shell

Interface
REQ-001 Parameter FIRE_KEY, default 8'h2C, is the keycode that fires a shell.
REQ-002 Parameter SHELL_STEP, default 4, is the shell displacement in pixels per frame.
REQ-003 Parameter SHELL_SIZE, default 2, is the shell half-size in pixels.
REQ-004 Parameter MUZZLE, default 16, is the spawn offset from tank centre along the facing direction.
REQ-005 Parameter COOLDOWN, default 30, is the number of frames after a shot ends before the next fire is accepted.
REQ-006 Parameters X_MAX = 639 and Y_MAX = 479 give the screen bounds.
REQ-007 frame_clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 Reset  in  1  synchronous, active-high reset.
REQ-009 keycode  in  8  current key from the keyboard interface.
REQ-010 TankX, TankY  in  10 each  firing tank centre.
REQ-011 rotation  in  3  firing tank facing: 000 right, 001 left, 010 down, 011 up; other values are invalid.
REQ-012 EnemyX, EnemyY, EnemySx, EnemySy  in  10 each  target tank centre and half-sizes.
REQ-013 enemy_field  in  1  target shield active.
REQ-014 game_over  in  1  game-over display active.
REQ-015 ShellX, ShellY  out  10 each  shell centre.
REQ-016 shell_active  out  1  shell on screen, used by the renderer.
REQ-017 shotHit  out  1  one-frame hit pulse to the target tank.
REQ-018 score  out  4  hits landed, saturating.

Function
REQ-019 The block SHALL implement states IDLE, FLIGHT, HIT and COOL; all outputs are registered.
REQ-020 Fire request is the rising edge of (keycode == FIRE_KEY); the previous-key register SHALL update every cycle in every state.
REQ-021 In IDLE, a fire request with a valid rotation SHALL load the spawn position and enter FLIGHT, with shell_active = 1 in the following cycle.
REQ-022 Spawn position is the tank centre offset by MUZZLE along the facing direction (right X+, left X-, down Y+, up Y-); the other coordinate equals the tank coordinate.
REQ-023 If the spawn coordinate falls outside [SHELL_SIZE, MAX-SHELL_SIZE], or rotation is invalid, the fire request SHALL be ignored and the block stays in IDLE.
REQ-024 Direction is latched at spawn; later rotation and tank-position changes SHALL NOT affect the shell in flight.
REQ-025 In FLIGHT, each cycle evaluates the hit test on the current position: |ShellX-EnemyX| <= EnemySx + SHELL_SIZE and |ShellY-EnemyY| <= EnemySy + SHELL_SIZE.
REQ-026 Hit with enemy_field = 0: go to HIT, set shell_active = 0, and increment score, saturating at 15.
REQ-027 Hit with enemy_field = 1: the shell is absorbed; go to COOL with shell_active = 0, no shotHit and no score change.
REQ-028 No hit, next position within bounds: add or subtract SHELL_STEP on the latched axis.
REQ-029 No hit, next position outside [SHELL_SIZE, MAX-SHELL_SIZE]: go to COOL with shell_active = 0.
REQ-030 A hit SHALL take priority over an out-of-bounds exit in the same cycle.
REQ-031 Arithmetic SHALL use 11-bit signed intermediates so that a coordinate never wraps through 0 or 1023.
REQ-032 In HIT, shotHit = 1 for exactly one cycle, then the block goes to COOL.
REQ-033 COOL loads the counter with COOLDOWN-1 on entry, decrements each cycle, and returns to IDLE after exactly COOLDOWN cycles in COOL.
REQ-034 Fire requests in FLIGHT, HIT or COOL SHALL be discarded and SHALL NOT be queued.
REQ-035 game_over = 1 SHALL force IDLE, set shell_active = 0 and shotHit = 0, clear the counter and hold score; this applies mid-flight and mid-cooldown.
REQ-036 ShellX and ShellY SHALL hold their last value whenever shell_active = 0.

Reset
REQ-037 Reset SHALL set state IDLE, ShellX = ShellY = 0, shell_active = 0, shotHit = 0, score = 0, counter = 0 and previous-key = 0, and takes priority over game_over.
REQ-038 Reset asserted mid-flight SHALL remove the shell in the next cycle with no shotHit.

Verification
REQ-039 Tank at (120,240), rotation 000, keycode 00 -> 2C: next cycle ShellX=136, ShellY=240, shell_active=1; ShellX=140 one cycle later.
REQ-040 Enemy at (200,240), size 16x16, field 0: shotHit high for one cycle when ShellX reaches 184, score=1, shell_active=0, then 30 cycles before a new fire is accepted.
REQ-041 Same setup with enemy_field=1: shell disappears at the same cycle, shotHit stays 0, score unchanged.
REQ-042 Tank at (10,100), rotation 001, fire: spawn rejected, shell_active stays 0; keycode held at 2C for 50 frames fires only once once a valid spawn exists.
REQ-043 Rotation 011 from (300,20): shell moves up to Y=4, then exits to COOL; assert game_over mid-flight -> shell_active=0 next cycle and score held.
REQ-044 Sixteen unshielded hits -> score saturates at 15.

Source files
------------

// File: rtl/tank_shell.sv
// tank_shell: single-shell launcher for a tank game.
// Spawns a shell at the muzzle, flies it, scores hits, then cools down.
module tank_shell #(
   parameter logic [7:0] FIRE_KEY   = 8'h2C,
   parameter int         SHELL_STEP = 4,
   parameter int         SHELL_SIZE = 2,
   parameter int         MUZZLE     = 16,
   parameter int         COOLDOWN   = 30,
   parameter int         X_MAX      = 639,
   parameter int         Y_MAX      = 479
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic [9:0] TankX,
   input  logic [9:0] TankY,
   input  logic [2:0] rotation,
   input  logic [9:0] EnemyX,
   input  logic [9:0] EnemyY,
   input  logic [9:0] EnemySx,
   input  logic [9:0] EnemySy,
   input  logic       enemy_field,
   input  logic       game_over,
   output logic [9:0] ShellX,
   output logic [9:0] ShellY,
   output logic       shell_active,
   output logic       shotHit,
   output logic [3:0] score
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLIGHT,
      S_HIT,
      S_COOL
   } state_t;

   localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(COOLDOWN - 1);

   localparam logic signed [10:0] MUZ  = 11'(MUZZLE);
   localparam logic signed [10:0] STEP = 11'(SHELL_STEP);
   localparam logic signed [10:0] LO   = 11'(SHELL_SIZE);
   localparam logic signed [10:0] XHI  = 11'(X_MAX - SHELL_SIZE);
   localparam logic signed [10:0] YHI  = 11'(Y_MAX - SHELL_SIZE);
   localparam logic [11:0]        SZ12 = 12'(SHELL_SIZE);

   state_t          state_q, state_d;
   logic [7:0]      key_prev_q;
   logic [9:0]      sx_q, sx_d;
   logic [9:0]      sy_q, sy_d;
   logic            act_q, act_d;
   logic            hit_q, hit_d;
   logic [3:0]      score_q, score_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      dir_q, dir_d;

   logic            fire;
   logic signed [10:0] tx, ty, spx, spy;
   logic            rot_ok, spawn_ok;
   logic signed [10:0] cx, cy, nx, ny;
   logic            next_in;
   logic signed [10:0] dx, dy;
   logic [10:0]     adx, ady;
   logic [11:0]     limx, limy;
   logic            hit;

   assign fire = (keycode == FIRE_KEY) && (key_prev_q != FIRE_KEY);

   // Muzzle position for the current tank pose and its validity.
   always_comb begin
      tx     = signed'({1'b0, TankX});
      ty     = signed'({1'b0, TankY});
      spx    = tx;
      spy    = ty;
      rot_ok = 1'b1;
      case (rotation)
         3'b000:  spx = tx + MUZ;
         3'b001:  spx = tx - MUZ;
         3'b010:  spy = ty + MUZ;
         3'b011:  spy = ty - MUZ;
         default: rot_ok = 1'b0;
      endcase
      spawn_ok = rot_ok
               && (spx >= LO) && (spx <= XHI)
               && (spy >= LO) && (spy <= YHI);
   end

   // Overlap test on the current shell and its next step on the latched axis.
   always_comb begin
      cx   = signed'({1'b0, sx_q});
      cy   = signed'({1'b0, sy_q});
      dx   = cx - signed'({1'b0, EnemyX});
      dy   = cy - signed'({1'b0, EnemyY});
      adx  = dx[10] ? (~dx + 11'sd1) : dx;
      ady  = dy[10] ? (~dy + 11'sd1) : dy;
      limx = {2'b00, EnemySx} + SZ12;
      limy = {2'b00, EnemySy} + SZ12;
      hit  = ({1'b0, adx} <= limx) && ({1'b0, ady} <= limy);
      nx   = cx;
      ny   = cy;
      case (dir_q)
         2'b00:   nx = cx + STEP;
         2'b01:   nx = cx - STEP;
         2'b10:   ny = cy + STEP;
         default: ny = cy - STEP;
      endcase
      next_in = (nx >= LO) && (nx <= XHI)
              && (ny >= LO) && (ny <= YHI);
   end

   // Next-state and registered-output values.
   always_comb begin
      state_d = state_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      act_d   = act_q;
      hit_d   = 1'b0;
      score_d = score_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      if (game_over) begin
         state_d = S_IDLE;
         act_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fire && spawn_ok) begin
                  state_d = S_FLIGHT;
                  sx_d    = spx[9:0];
                  sy_d    = spy[9:0];
                  act_d   = 1'b1;
                  dir_d   = rotation[1:0];
               end
            end
            S_FLIGHT: begin
               if (hit) begin
                  act_d = 1'b0;
                  if (enemy_field) begin
                     state_d = S_COOL;
                     cnt_d   = CNT_INIT;
                  end else begin
                     state_d = S_HIT;
                     hit_d   = 1'b1;
                     if (score_q != 4'hF) score_d = score_q + 4'd1;
                  end
               end else if (next_in) begin
                  sx_d = nx[9:0];
                  sy_d = ny[9:0];
               end else begin
                  act_d   = 1'b0;
                  state_d = S_COOL;
                  cnt_d   = CNT_INIT;
               end
            end
            S_HIT: begin
               state_d = S_COOL;
               cnt_d   = CNT_INIT;
            end
            default: begin
               if (cnt_q == '0) state_d = S_IDLE;
               else cnt_d = cnt_q - CW'(1);
            end
         endcase
      end
   end

   // State and output registers; the key history updates every frame.
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         key_prev_q <= '0;
         sx_q       <= '0;
         sy_q       <= '0;
         act_q      <= 1'b0;
         hit_q      <= 1'b0;
         score_q    <= '0;
         cnt_q      <= '0;
         dir_q      <= '0;
      end else begin
         state_q    <= state_d;
         key_prev_q <= keycode;
         sx_q       <= sx_d;
         sy_q       <= sy_d;
         act_q      <= act_d;
         hit_q      <= hit_d;
         score_q    <= score_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
      end
   end

   assign ShellX       = sx_q;
   assign ShellY       = sy_q;
   assign shell_active = act_q;
   assign shotHit      = hit_q;
   assign score        = score_q;

endmodule
